// File: rtl/cory_demuxb_if.sv
// Handshake bundle for cory_demuxb: upstream beat stream, select tokens and
// the R per-channel output streams. The DUT uses the slave modport.
interface cory_demuxb_if #(
  parameter int N = 8,
  parameter int R = 4,
  parameter int C = 8,
  parameter int S = (R > 1) ? $clog2(R) : 1,
  parameter int D = R * N
);
  logic         i_a_v;
  logic [N-1:0] i_a_d;
  logic         o_a_r;
  logic         i_s_v;
  logic [S-1:0] i_s_d;
  logic [C-1:0] i_s_n;
  logic         o_s_r;
  logic [R-1:0] o_zx_v;
  logic [D-1:0] o_zx_d;
  logic [R-1:0] i_zx_r;
  logic         o_busy;
  logic         dbg_state;

  // All streams use valid/ready: a transfer happens on a rising clk edge
  // where valid and ready are both 1; valid with its data must then hold
  // steady until that edge, and ready may depend on the other side's state.
  modport slave (
    input  i_a_v, i_a_d, i_s_v, i_s_d, i_s_n, i_zx_r,
    output o_a_r, o_s_r, o_zx_v, o_zx_d, o_busy, dbg_state
  );

  modport master (
    output i_a_v, i_a_d, i_s_v, i_s_d, i_s_n, i_zx_r,
    input  o_a_r, o_s_r, o_zx_v, o_zx_d, o_busy, dbg_state
  );
endinterface

// File: rtl/cory_demuxb.sv
// Burst demux: one select token steers (i_s_n+1) beats to channel i_s_d,
// each channel behind a one-entry slice. CORY_DEMUXB_ERR_EN adds sticky o_err.
module cory_demuxb #(
  parameter int N = 8,
  parameter int R = 4,
  parameter int C = 8,
  parameter int S = (R > 1) ? $clog2(R) : 1,
  parameter int D = R * N
) (
  input  logic clk,
  input  logic reset,
  cory_demuxb_if.slave bus
`ifdef CORY_DEMUXB_ERR_EN
  ,
  output logic o_err
`endif
);
  typedef enum logic {IDLE = 1'b0, ROUTE = 1'b1} state_t;

  localparam logic [S:0] R_EXT = (S + 1)'(R);

  state_t       state;
  logic [S-1:0] sel;
  logic [C-1:0] cnt;
  logic         s_r_q;
  logic [R-1:0] slot_v;
  logic [N-1:0] slot_d [R];
  logic [D-1:0] zx_d;
  logic         sel_oor;
  logic         sel_free;
  logic         a_fire;
  logic         s_fire;

  // Out-of-range channels swallow beats, so they are always ready.
  assign sel_oor = {1'b0, sel} >= R_EXT;

  always_comb begin
    sel_free = 1'b0;
    for (int k = 0; k < R; k++) begin
      if (sel == S'(k)) sel_free = !slot_v[k] | bus.i_zx_r[k];
    end
  end

  assign bus.o_a_r     = (state == ROUTE) & (sel_oor | sel_free);
  assign bus.o_s_r     = s_r_q;
  assign a_fire        = bus.i_a_v & bus.o_a_r;
  assign s_fire        = bus.i_s_v & s_r_q;
  assign bus.o_zx_v    = slot_v;
  assign bus.o_zx_d    = zx_d;
  assign bus.o_busy    = (state == ROUTE) | (|slot_v);
  assign bus.dbg_state = state;

  // o_s_r is registered, so it rises one cycle after reset is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sel   <= '0;
      cnt   <= '0;
      s_r_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          s_r_q <= 1'b1;
          if (s_fire) begin
            sel   <= bus.i_s_d;
            cnt   <= bus.i_s_n;
            state <= ROUTE;
            s_r_q <= 1'b0;
          end
        end
        ROUTE: begin
          if (a_fire) begin
            if (cnt == '0) begin
              state <= IDLE;
              s_r_q <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          s_r_q <= 1'b0;
        end
      endcase
    end
  end

  // A load wins over a drain, which keeps a slot full at one beat per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_v <= '0;
      for (int k = 0; k < R; k++) slot_d[k] <= '0;
    end else begin
      for (int k = 0; k < R; k++) begin
        if (a_fire && (sel == S'(k))) begin
          slot_v[k] <= 1'b1;
          slot_d[k] <= bus.i_a_d;
        end else if (bus.i_zx_r[k]) begin
          slot_v[k] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    zx_d = '0;
    for (int k = 0; k < R; k++) zx_d[k*N +: N] = slot_d[k];
  end

`ifdef CORY_DEMUXB_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else if (s_fire && ({1'b0, bus.i_s_d} >= R_EXT)) err_q <= 1'b1;
  end

  assign o_err = err_q;
`endif
endmodule

// File: doc/cory_demuxb.md
Name: cory_demuxb

Overview:
- Parametrised burst demux: one upstream valid/ready stream, routed to one of R output channels.
- Each select token carries a channel index and a beat count, so one select steers a whole burst. The older per-beat demux needs one select handshake per beat.
- Each output channel has a one-entry register slice, so downstream timing is decoupled.
- Sits between a packet source and per-channel consumers. Any R from 2 to 32 is supported; R need not be a power of two.

Parameters:
- N, 8, data width per beat.
- R, 4, number of output channels, 2..32.
- S, ceil(log2(R)) with minimum 1, select width; derived, do not override.
- C, 8, burst-length field width.
- D, R*N, concatenated output data width; derived, do not override.

Ports:
- clk  input  1  clock; all logic rising-edge.
- reset  input  1  synchronous reset, active-high.
- i_a_v  input  1  upstream beat valid.
- i_a_d  input  N  upstream beat data.
- o_a_r  output  1  upstream beat ready.
- i_s_v  input  1  select token valid.
- i_s_d  input  S  select channel index.
- i_s_n  input  C  burst length minus one (0 = 1 beat).
- o_s_r  output  1  select token ready.
- o_zx_v  output  R  per-channel valid; bit k = channel k.
- o_zx_d  output  D  per-channel data; bits [k*N +: N] = channel k.
- i_zx_r  input  R  per-channel ready.
- o_busy  output  1  burst in progress or any slot occupied.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values, held while reset=1:
  - state=IDLE; all slots empty.
  - o_zx_v=0, o_zx_d=0, o_a_r=0, o_s_r=0, o_busy=0.
- IDLE state:
  - o_s_r=1, o_a_r=0.
  - When i_s_v&o_s_r: latch sel=i_s_d and cnt=i_s_n, go to ROUTE.
- ROUTE state:
  - o_s_r=0.
  - o_a_r = sel>=R ? 1 : (!slot_v[sel] | i_zx_r[sel]).
  - On i_a_v&o_a_r: if cnt==0, go to IDLE next cycle; else cnt=cnt-1.
  - i_a_d never loads a slot other than sel.
- Out-of-range select (sel>=R): beats are accepted and discarded, with the same count accounting. No output is asserted.
- Throughput: a burst of L beats needs at least L+1 cycles (one select bubble). A beat accepted in the last burst cycle is not lost.
- Slot k:
  - Load when a beat is accepted with sel==k: slot_v=1, slot_d=i_a_d.
  - Clear slot_v when o_zx_v[k]&i_zx_r[k] with no load in the same cycle.
  - Load and drain in the same cycle: new data, valid stays 1 (full rate).
- Latency: beat accepted in cycle t appears on o_zx_v/o_zx_d in cycle t+1.
- Ready path: o_a_r depends combinationally on i_zx_r[sel]; no other combinational input-to-output path.
- o_zx_d[k] holds its last value when slot k is empty; X is not permitted.
- o_busy = (state==ROUTE) | (|slot_v).
- Once o_zx_v[k]=1, it stays 1 and o_zx_d[k] stays stable until i_zx_r[k]=1.
- Simultaneous events: i_s_v in ROUTE is ignored (not accepted). i_a_v in IDLE is not accepted.
- Reset mid-burst: the burst is aborted, slot contents are dropped, and IDLE is entered the cycle after reset deasserts.
- cnt wrap: i_s_n = 2^C-1 gives 2^C beats. cnt never underflows.

Optional Feature:
- Macro: CORY_DEMUXB_ERR_EN.
- With macro: adds port o_err (output, 1 bit).
  - o_err is sticky; it sets the cycle after a select with i_s_d>=R is accepted.
  - Cleared only by reset.
  - Never sets when R is a power of two.
- Without macro: port o_err is absent. Out-of-range bursts are still silently drained.

Test Plan:
- R=4, N=8: select (2, n=3), beats 0x11..0x14, i_zx_r=4'hF -> o_zx_v[2] pulses 4 consecutive cycles with 0x11..0x14, each 1 cycle after acceptance. Other channels stay 0, o_busy drops after the last drain.
- R=4: select (1, n=1), i_zx_r[1]=0 -> first beat latched and o_a_r=0. Second beat stalls until i_zx_r[1]=1, then 0xA0 and 0xA1 are delivered in order; o_zx_d stable while stalled.
- R=3, ERR_EN defined: select (3, n=2), 3 beats -> all beats accepted back-to-back, o_zx_v=0 throughout, o_err=1 from the cycle after the select and stays 1.
- R=8: selects (0,n=0), (7,n=0), (0,n=0), one beat each -> each select takes 2 cycles, o_s_r=0 in ROUTE. Channels 0, 7, 0 receive data in order.
- R=4: reset=1 asserted after the 2nd of 4 beats (sel=3) -> next cycle all o_zx_v=0 and o_s_r=0. After deassert o_s_r=1 and state IDLE; a new burst (0, n=0) completes correctly.
- C=2: select (1, n=3) -> exactly 4 beats accepted, then o_a_r=0 and o_s_r=1.
